pipe_queue: RTL and testbench

PIPE_QUEUE -- requirements
Module: pipe_queue

---
 rtl/pipe_queue.sv | 115 +++++++++++
 tb/tb_pipe_queue.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_queue.sv
// Ready/valid queue: a DEPTH-entry ring buffer feeding one registered output stage.
// Optional macro PIPE_QUEUE_BYPASS_EN lets an input skip the empty ring for 1-cycle latency.
module pipe_queue #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned AFULL_LEVEL = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         valid_in,
  input  logic [DATA_WIDTH-1:0]        data_in,
  output logic                         ready_in,
  output logic                         valid_out,
  output logic [DATA_WIDTH-1:0]        data_out,
  input  logic                         ready_out,
  output logic [$clog2(DEPTH+2)-1:0]   count,
  output logic                         afull
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned NW = $clog2(DEPTH + 2);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         occ_q, occ_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic ring_empty, ring_full, accept, advance, bypass, push, pop, write_en;

  // Handshake decode and next-state computation.
  always_comb begin
    ring_empty = (occ_q == '0);
    ring_full  = (occ_q == CW'(DEPTH));
    accept     = valid_in && !ring_full;
    advance    = !valid_q || ready_out;
`ifdef PIPE_QUEUE_BYPASS_EN
    bypass     = advance && ring_empty && accept;
`else
    bypass     = 1'b0;
`endif
    pop        = advance && !ring_empty;
    push       = accept && !bypass;
    write_en   = push && !flush;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    valid_d  = valid_q;
    data_d   = data_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    occ_d = occ_q + CW'(push) - CW'(pop);

    if (advance) begin
      if (pop) begin
        valid_d = 1'b1;
        data_d  = mem_q[rd_ptr_q];
      end else if (bypass) begin
        valid_d = 1'b1;
        data_d  = data_in;
      end else begin
        valid_d = 1'b0;
        data_d  = '0;
      end
    end

    // Flush discards everything, including an input offered this cycle.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
      valid_d  = 1'b0;
      data_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

  // Ring storage carries no reset; occupancy alone qualifies its contents.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign ready_in  = !ring_full;
  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign count     = NW'(occ_q) + NW'(valid_q);
  assign afull     = (occ_q >= CW'(AFULL_LEVEL));

endmodule

// File: tb/tb_pipe_queue.sv
// Directed and randomized self-checking bench for pipe_queue (DEPTH 4 directed, DEPTH 2 and 8 random).
module tb_pipe_queue;

  logic       clk = 1'b0;
  logic       reset, flush, valid_in, ready_out;
  logic [7:0] data_in;
  logic       ready_in, valid_out, afull;
  logic [7:0] data_out;
  logic [2:0] count;

  logic       r_valid_in  [2];
  logic [7:0] r_data_in   [2];
  logic       r_ready_out [2];
  logic       r_ready_in  [2];
  logic       r_valid_out [2];
  logic [7:0] r_data_out  [2];
  logic [3:0] r_count     [2];
  logic       r_afull     [2];

  int unsigned sent [2];
  int unsigned recv [2];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_queue #(.DATA_WIDTH(8), .DEPTH(4)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .valid_in(valid_in), .data_in(data_in),
    .ready_in(ready_in), .valid_out(valid_out), .data_out(data_out), .ready_out(ready_out),
    .count(count), .afull(afull)
  );

  for (genvar g = 0; g < 2; g++) begin : g_rnd
    localparam int unsigned D = (g == 0) ? 2 : 8;
    logic [$clog2(D+2)-1:0] cnt_w;
    pipe_queue #(.DATA_WIDTH(8), .DEPTH(D)) u_dut (
      .clk(clk), .reset(reset), .flush(1'b0), .valid_in(r_valid_in[g]), .data_in(r_data_in[g]),
      .ready_in(r_ready_in[g]), .valid_out(r_valid_out[g]), .data_out(r_data_out[g]),
      .ready_out(r_ready_out[g]), .count(cnt_w), .afull(r_afull[g])
    );
    assign r_count[g] = 4'(cnt_w);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      valid_in = 1'b1;
      data_in  = first + 8'(i);
      tick();
    end
    valid_in = 1'b0;
    data_in  = 8'h00;
  endtask

  // One cycle of the random phase: score handshakes at current state, then pick new inputs.
  task automatic rnd_cycle(input bit drain);
    for (int g = 0; g < 2; g++) begin
      int unsigned d;
      int unsigned occ;
      d   = (g == 0) ? 2 : 8;
      occ = 32'(r_count[g]) - 32'(r_valid_out[g]);
      check("rnd_count_max", 32'(32'(r_count[g]) <= d + 1), 32'd1);
      check("rnd_afull", 32'(r_afull[g]), 32'(occ >= d - 1));
      if (r_valid_out[g] && r_ready_out[g]) begin
        check("rnd_data", 32'(r_data_out[g]), 32'(8'(recv[g])));
        recv[g]++;
      end
      if (r_valid_in[g] && r_ready_in[g]) sent[g]++;
    end
    tick();
    for (int g = 0; g < 2; g++) begin
      r_valid_in[g]  = drain ? 1'b0 : 1'($urandom_range(0, 1));
      r_ready_out[g] = drain ? 1'b1 : 1'($urandom_range(0, 1));
      r_data_in[g]   = 8'(sent[g]);
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; valid_in = 1'b0; data_in = 8'h00; ready_out = 1'b0;
    for (int g = 0; g < 2; g++) begin
      r_valid_in[g] = 1'b0; r_data_in[g] = 8'h00; r_ready_out[g] = 1'b0;
      sent[g] = 0; recv[g] = 0;
    end
    tick(); tick();
    reset = 1'b0;
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_data",  32'(data_out),  32'd0);
    check("rst_count", 32'(count),     32'd0);
    check("rst_afull", 32'(afull),     32'd0);
    check("rst_ready", 32'(ready_in),  32'd1);

    // First-transfer latency.
    valid_in = 1'b1; data_in = 8'hA5; ready_out = 1'b1;
    tick();
    valid_in = 1'b0; data_in = 8'h00;
`ifndef PIPE_QUEUE_BYPASS_EN
    check("lat_early", 32'(valid_out), 32'd0);
    tick();
`endif
    check("lat_valid", 32'(valid_out), 32'd1);
    check("lat_data",  32'(data_out),  32'hA5);
    tick();
    check("lat_drain", 32'(valid_out), 32'd0);
    check("lat_count", 32'(count),     32'd0);

    // Fill to capacity with output stalled, then drain in order.
    ready_out = 1'b0;
    for (int i = 0; i < 6; i++) begin
      valid_in = 1'b1;
      data_in  = 8'(i + 1);
      check("fill_ready", 32'(ready_in), 32'(i < 5));
      tick();
    end
    valid_in = 1'b0;
    check("full_count", 32'(count),     32'd5);
    check("full_afull", 32'(afull),     32'd1);
    check("full_ready", 32'(ready_in),  32'd0);
    check("full_head",  32'(data_out),  32'd1);
    ready_out = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      check("drain_valid", 32'(valid_out), 32'd1);
      check("drain_data",  32'(data_out),  32'(i));
      tick();
    end
    check("drain_empty", 32'(valid_out), 32'd0);
    check("drain_count", 32'(count),     32'd0);

    // Full ring with output advancing: no acceptance this cycle, slot free next cycle.
    ready_out = 1'b0;
    push_seq(8'h11, 5);
    valid_in = 1'b1; data_in = 8'h16; ready_out = 1'b1;
    check("fullpop_ready0", 32'(ready_in), 32'd0);
    tick();
    check("fullpop_ready1", 32'(ready_in), 32'd1);
    check("fullpop_head",   32'(data_out), 32'h12);
    check("fullpop_count",  32'(count),    32'd4);
    tick();
    valid_in = 1'b0; data_in = 8'h00;
    check("fullpop_count2", 32'(count), 32'd4);
    for (int k = 8'h13; k <= 8'h16; k++) begin
      check("fullpop_valid", 32'(valid_out), 32'd1);
      check("fullpop_data",  32'(data_out),  32'(k));
      tick();
    end
    check("fullpop_empty", 32'(valid_out), 32'd0);

    // Flush with three entries held and an input offered.
    ready_out = 1'b0;
    push_seq(8'h21, 3);
    check("pre_flush_count", 32'(count), 32'd3);
    check("pre_flush_afull", 32'(afull), 32'd0);
    flush = 1'b1; valid_in = 1'b1; data_in = 8'h07;
    tick();
    flush = 1'b0; valid_in = 1'b0; data_in = 8'h00; ready_out = 1'b1;
    check("flush_valid", 32'(valid_out), 32'd0);
    check("flush_data",  32'(data_out),  32'd0);
    check("flush_count", 32'(count),     32'd0);
    check("flush_ready", 32'(ready_in),  32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flush_no7", 32'(valid_out), 32'd0);
    end

    // Reset with data held and handshakes active.
    ready_out = 1'b0;
    push_seq(8'h31, 3);
    check("pre_rst_count", 32'(count), 32'd3);
    reset = 1'b1; valid_in = 1'b1; data_in = 8'h34; ready_out = 1'b1;
    tick();
    reset = 1'b0; valid_in = 1'b0; data_in = 8'h00;
    check("rst2_valid", 32'(valid_out), 32'd0);
    check("rst2_data",  32'(data_out),  32'd0);
    check("rst2_count", 32'(count),     32'd0);
    check("rst2_afull", 32'(afull),     32'd0);
    check("rst2_ready", 32'(ready_in),  32'd1);

    // Random traffic on the DEPTH=2 and DEPTH=8 instances.
    for (int g = 0; g < 2; g++) begin
      r_valid_in[g]  = 1'($urandom_range(0, 1));
      r_ready_out[g] = 1'($urandom_range(0, 1));
      r_data_in[g]   = 8'h00;
    end
    for (int c = 0; c < 10000; c++) rnd_cycle(1'b0);
    for (int c = 0; c < 12; c++) rnd_cycle(1'b1);
    for (int g = 0; g < 2; g++) begin
      check("rnd_progress", 32'(sent[g] > 100), 32'd1);
      check("rnd_all_out",  recv[g],            sent[g]);
      check("rnd_end_count", 32'(r_count[g]),   32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
